// File: rtl/img_sram_pkg.sv
// Shared types and default widths for the image SRAM datapath blocks.
package img_sram_pkg;

    localparam int IMG_ROW_W  = 8;
    localparam int IMG_COL_W  = 8;
    localparam int IMG_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } io_rx_state_e;

    // Bundled SRAM port view for glue logic at the default widths.
    typedef struct packed {
        logic                  sense_en;
        logic                  write_en;
        logic [IMG_ROW_W-1:0]  row;
        logic [IMG_COL_W-1:0]  col;
        logic [IMG_DATA_W-1:0] din;
    } img_sram_ctrl_t;

endpackage

// File: rtl/io_rx_stream_writer.sv
// Streams pixels from a valid/ready input into a programmable SRAM window in raster order.
// Optional running checksum enabled by defining IO_RX_CHECKSUM_EN.
module io_rx_stream_writer
    import img_sram_pkg::*;
#(
    parameter int DATA_W = IMG_DATA_W,
    parameter int ROW_W  = IMG_ROW_W,
    parameter int COL_W  = IMG_COL_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ROW_W-1:0]     nrows,
    input  logic [COL_W-1:0]     ncols,
    input  logic [ROW_W-1:0]     row_base,
    input  logic [COL_W-1:0]     col_base,
    input  logic [DATA_W-1:0]    din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 sram_sense_en,
    output logic                 sram_write_en,
    output logic [ROW_W-1:0]     sram_row,
    output logic [COL_W-1:0]     sram_col,
    output logic [DATA_W-1:0]    sram_din,
    output logic [DATA_W+15:0]   checksum
);

    io_rx_state_e     state;
    logic [ROW_W-1:0] nrows_l;
    logic [COL_W-1:0] ncols_l;
    logic [ROW_W-1:0] row_base_l;
    logic [COL_W-1:0] col_base_l;
    logic [ROW_W-1:0] row_idx;
    logic [COL_W-1:0] col_idx;
    logic             accept;
    logic             last_col;
    logic             last_pix;
    logic             launch;

    // Handshake and done react to abort in the same cycle so no beat slips through.
    assign din_ready     = (state == RUN) && !abort;
    assign accept        = din_valid && din_ready;
    assign busy          = (state != IDLE);
    assign done          = (state == FIN) && !abort;
    assign sram_sense_en = 1'b1;

    assign last_col = (col_idx == ncols_l);
    assign last_pix = last_col && (row_idx == nrows_l);
    assign launch   = (state == IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            nrows_l       <= '0;
            ncols_l       <= '0;
            row_base_l    <= '0;
            col_base_l    <= '0;
            row_idx       <= '0;
            col_idx       <= '0;
            sram_write_en <= 1'b0;
            sram_row      <= '0;
            sram_col      <= '0;
            sram_din      <= '0;
        end else begin
            sram_write_en <= 1'b0;
            if (accept) begin
                sram_write_en <= 1'b1;
                sram_row      <= row_base_l + row_idx;
                sram_col      <= col_base_l + col_idx;
                sram_din      <= din;
                if (last_col) begin
                    col_idx <= '0;
                    row_idx <= row_idx + 1'b1;
                end else begin
                    col_idx <= col_idx + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (launch) begin
                        nrows_l    <= nrows;
                        ncols_l    <= ncols;
                        row_base_l <= row_base;
                        col_base_l <= col_base;
                        row_idx    <= '0;
                        col_idx    <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (accept && last_pix) begin
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IO_RX_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            checksum <= '0;
        end else if (launch) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + {{16{1'b0}}, din};
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_io_rx_stream_writer.sv
// Randomised self-checking bench for io_rx_stream_writer against a frame-level reference model.
module tb_io_rx_stream_writer;

    localparam int DATA_W = 8;
    localparam int ROW_W  = 8;
    localparam int COL_W  = 8;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [ROW_W-1:0]    nrows = '0;
    logic [COL_W-1:0]    ncols = '0;
    logic [ROW_W-1:0]    row_base = '0;
    logic [COL_W-1:0]    col_base = '0;
    logic [DATA_W-1:0]   din = '0;
    logic                din_valid = 1'b0;
    logic                din_ready;
    logic                busy;
    logic                done;
    logic                sram_sense_en;
    logic                sram_write_en;
    logic [ROW_W-1:0]    sram_row;
    logic [COL_W-1:0]    sram_col;
    logic [DATA_W-1:0]   sram_din;
    logic [DATA_W+15:0]  checksum;

    int tests = 0;
    int fails = 0;

    io_rx_stream_writer #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .nrows(nrows), .ncols(ncols), .row_base(row_base), .col_base(col_base),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .busy(busy), .done(done), .sram_sense_en(sram_sense_en),
        .sram_write_en(sram_write_en), .sram_row(sram_row), .sram_col(sram_col),
        .sram_din(sram_din), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Frame-level model: pixel k of a frame lands at (base + k / cols, base + k % cols).
    bit                 m_run = 1'b0;
    bit                 m_fin = 1'b0;
    int                 m_k = 0;
    int                 m_total = 0;
    int                 m_nc = 0;
    int                 m_rb = 0;
    int                 m_cb = 0;
    logic               m_we = 1'b0;
    logic [ROW_W-1:0]   m_row = '0;
    logic [COL_W-1:0]   m_col = '0;
    logic [DATA_W-1:0]  m_din = '0;
    logic [DATA_W+15:0] m_sum = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_run <= 1'b0; m_fin <= 1'b0; m_k <= 0; m_total <= 0;
            m_we <= 1'b0; m_row <= '0; m_col <= '0; m_din <= '0; m_sum <= '0;
        end else begin
            m_we <= 1'b0;
            if (m_fin) begin
                m_fin <= 1'b0;
            end else if (m_run) begin
                if (abort) begin
                    m_run <= 1'b0;
                end else if (din_valid) begin
                    m_we  <= 1'b1;
                    m_row <= ROW_W'(m_rb + m_k / (m_nc + 1));
                    m_col <= COL_W'(m_cb + m_k % (m_nc + 1));
                    m_din <= din;
`ifdef IO_RX_CHECKSUM_EN
                    m_sum <= m_sum + (DATA_W+16)'(din);
`endif
                    m_k <= m_k + 1;
                    if (m_k + 1 == m_total) begin
                        m_run <= 1'b0;
                        m_fin <= 1'b1;
                    end
                end
            end else if (start && !abort) begin
                m_run   <= 1'b1;
                m_k     <= 0;
                m_nc    <= int'(ncols);
                m_rb    <= int'(row_base);
                m_cb    <= int'(col_base);
                m_total <= (int'(nrows) + 1) * (int'(ncols) + 1);
                m_sum   <= '0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("din_ready", 32'(din_ready), 32'(m_run && !abort));
        checkOutput("busy", 32'(busy), 32'(m_run || m_fin));
        checkOutput("done", 32'(done), 32'(m_fin && !abort));
        checkOutput("sram_sense_en", 32'(sram_sense_en), 32'd1);
        checkOutput("sram_write_en", 32'(sram_write_en), 32'(m_we));
        checkOutput("sram_row", 32'(sram_row), 32'(m_row));
        checkOutput("sram_col", 32'(sram_col), 32'(m_col));
        checkOutput("sram_din", 32'(sram_din), 32'(m_din));
        checkOutput("checksum", 32'(checksum), 32'(m_sum));
    end

    // Per-frame observations of the DUT, pinned against hand-computed literals.
    int               wr_cnt = 0;
    int               done_cnt = 0;
    bit               first_seen = 1'b0;
    logic [ROW_W-1:0] first_row = '0;
    logic [COL_W-1:0] first_col = '0;
    logic [ROW_W-1:0] last_row = '0;
    logic [COL_W-1:0] last_col = '0;
    logic [DATA_W-1:0] last_din = '0;
    bit               done_with_write = 1'b1;

    always @(negedge clk) begin
        if (rstn) begin
            if (sram_write_en) begin
                wr_cnt++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_row = sram_row;
                    first_col = sram_col;
                end
                last_row = sram_row;
                last_col = sram_col;
                last_din = sram_din;
            end
            if (done) begin
                done_cnt++;
                if (!sram_write_en) done_with_write = 1'b0;
            end
        end
    end

    // vmode: 0 continuous, 1 alternating, 2 random. pix: -1 counts 1..N, -2 random, else constant.
    task automatic applyStimulus(input int nr, input int nc, input int rb, input int cb,
                                 input int vmode, input int abort_at, input int pix,
                                 input bit poke_start);
        wr_cnt = 0; done_cnt = 0; first_seen = 1'b0; done_with_write = 1'b1;
        nrows = ROW_W'(nr); ncols = COL_W'(nc);
        row_base = ROW_W'(rb); col_base = COL_W'(cb);
        start = 1'b1; abort = 1'b0; din_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc <= 2000; cyc++) begin
            if (!(m_run || m_fin)) break;
            if (cyc == 2000) begin
                checkOutput("frame_timeout", 32'd1, 32'd0);
                break;
            end
            nrows = ROW_W'($urandom); ncols = COL_W'($urandom);
            row_base = ROW_W'($urandom); col_base = COL_W'($urandom);
            start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            case (vmode)
                0:       din_valid = 1'b1;
                1:       din_valid = (cyc % 2 == 0);
                default: din_valid = 1'($urandom_range(0, 1));
            endcase
            if (pix == -1)      din = DATA_W'(m_k + 1);
            else if (pix == -2) din = DATA_W'($urandom);
            else                din = DATA_W'(pix);
            abort = (abort_at >= 0) && (m_k == abort_at) && m_run;
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; din_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        $display("[TB] io_rx_stream_writer bench starting");
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_write_en", 32'(sram_write_en), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_beats_start", 32'(busy), 32'd0);
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1, 2, 0, 0, 0, -1, -1, 1'b0);
        checkOutput("t1_writes", 32'(wr_cnt), 32'd6);
        checkOutput("t1_done", 32'(done_cnt), 32'd1);
        checkOutput("t1_done_with_write", 32'(done_with_write), 32'd1);
        checkOutput("t1_first", {16'd0, first_row, first_col}, 32'h0000);
        checkOutput("t1_last", {8'd0, last_row, last_col, last_din}, 32'h010206);

        applyStimulus(1, 2, 0, 0, 1, -1, -1, 1'b0);
        checkOutput("t2_writes", 32'(wr_cnt), 32'd6);
        checkOutput("t2_done", 32'(done_cnt), 32'd1);
        checkOutput("t2_last", {8'd0, last_row, last_col, last_din}, 32'h010206);

        applyStimulus(2, 1, 254, 255, 0, -1, -1, 1'b0);
        checkOutput("t3_writes", 32'(wr_cnt), 32'd6);
        checkOutput("t3_first", {16'd0, first_row, first_col}, 32'hFEFF);
        checkOutput("t3_last", {16'd0, last_row, last_col}, 32'h0000);

        applyStimulus(1, 2, 0, 0, 0, 3, -1, 1'b0);
        checkOutput("t4_abort_writes", 32'(wr_cnt), 32'd3);
        checkOutput("t4_abort_no_done", 32'(done_cnt), 32'd0);
        checkOutput("t4_idle_after", 32'(busy), 32'd0);
        applyStimulus(1, 2, 0, 0, 0, -1, -1, 1'b0);
        checkOutput("t4_restart_writes", 32'(wr_cnt), 32'd6);
        checkOutput("t4_restart_first", {16'd0, first_row, first_col}, 32'h0000);

        applyStimulus(0, 0, 7, 9, 0, -1, -1, 1'b1);
        checkOutput("t5_single_writes", 32'(wr_cnt), 32'd1);
        checkOutput("t5_single_done", 32'(done_cnt), 32'd1);
        checkOutput("t5_single_addr", {16'd0, last_row, last_col}, 32'h0709);

        applyStimulus(1, 1, 0, 0, 0, -1, 255, 1'b0);
`ifdef IO_RX_CHECKSUM_EN
        checkOutput("t6_checksum", 32'(checksum), 32'h3FC);
`else
        checkOutput("t6_checksum", 32'(checksum), 32'h0);
`endif

        for (int i = 0; i < 25; i++) begin
            int nr = $urandom_range(0, 3);
            int nc = $urandom_range(0, 4);
            int ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (nr + 1) * (nc + 1) - 1)) : -1;
            applyStimulus(nr, nc, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          2, ab, -2, 1'($urandom_range(0, 1)));
        end

        nrows = 8'd3; ncols = 8'd3; row_base = 8'd10; col_base = 8'd20;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; din_valid = 1'b1; din = 8'hA5;
        repeat (3) begin @(posedge clk); #1; end
        #2 rstn = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_ready", 32'(din_ready), 32'd0);
        checkOutput("arst_write_en", 32'(sram_write_en), 32'd0);
        checkOutput("arst_addr", {16'd0, sram_row, sram_col}, 32'd0);
        checkOutput("arst_din", 32'(sram_din), 32'd0);
        checkOutput("arst_checksum", 32'(checksum), 32'd0);
        din_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 2, 0, 0, 0, -1, -1, 1'b0);
        checkOutput("post_reset_writes", 32'(wr_cnt), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
